// File: rtl/mod_inverse_stream.sv
// mod_inverse_stream
//    Streaming modular inverse a^-1 mod m using the binary extended Euclid
//    algorithm, one state action per clock.
//
// Ports
//    clk                    clock, rising edge
//    rst                    asynchronous reset, active low
//    input_base_t*          base a (tdata/tvalid/tready)
//    input_modulus_t*       modulus m (tdata/tvalid/tready); both operands
//                           transfer together in the same cycle
//    output_tdata           inverse in [0, m), 0 on error
//    output_tuser           error: no inverse or illegal operands
//    output_tvalid/tready   result handshake
//    busy                   high whenever the engine is not idle
//
// state   | meaning
// IDLE    | waiting for both operands
// CHECK   | reject even m, m < 3, a == 0, a >= m
// HALVE_U | strip factors of two from u, halve x1 mod m
// HALVE_V | strip factors of two from v, halve x2 mod m
// SUB     | subtract the smaller of u/v from the larger, same on x1/x2
// DONE    | result held until output_tready

module mod_inverse_stream #(
   parameter int SIZE     = 64,
   parameter int MAX_ITER = 4*SIZE+4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] input_base_tdata,
   input  logic            input_base_tvalid,
   output logic            input_base_tready,
   input  logic [SIZE-1:0] input_modulus_tdata,
   input  logic            input_modulus_tvalid,
   output logic            input_modulus_tready,
   output logic [SIZE-1:0] output_tdata,
   output logic            output_tuser,
   output logic            output_tvalid,
   input  logic            output_tready,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, CHECK, HALVE_U, HALVE_V, SUB, DONE} state_t;

   localparam int IW = $clog2(MAX_ITER+1);
   localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER-1);

   state_t          state, state_nxt;
   logic [SIZE-1:0] u, u_nxt, v, v_nxt, x1, x1_nxt, x2, x2_nxt, m_q, m_nxt;
   logic [SIZE-1:0] dout, dout_nxt;
   logic            derr, derr_nxt;
   logic [IW-1:0]   iter, iter_nxt;
   logic [1:0]      rst_sync;
   logic            run;
   logic            accept;

   // x/2 mod m for odd m: odd x becomes (x+m)/2, formed in SIZE+1 bits
   function automatic logic [SIZE-1:0] half_mod(input logic [SIZE-1:0] x,
                                                input logic [SIZE-1:0] m);
      logic [SIZE:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return s[SIZE:1];
   endfunction

   // (x - y) mod m for x, y in [0, m)
   function automatic logic [SIZE-1:0] sub_mod(input logic [SIZE-1:0] x,
                                               input logic [SIZE-1:0] y,
                                               input logic [SIZE-1:0] m);
      logic [SIZE:0] d;
      d = {1'b0, x} - {1'b0, y};
      if (d[SIZE])
         d = d + {1'b0, m};
      return d[SIZE-1:0];
   endfunction

   // Reset release is re-timed through two flops; acceptance waits for it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rst_sync <= 2'b00;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run = rst_sync[1];

   // While rst is held low the ports present the idle view (ready high);
   // between release and sync completion ready stays low so no transfer is lost.
   assign input_base_tready    = (state == IDLE) && (run || !rst);
   assign input_modulus_tready = input_base_tready;
   assign accept = (state == IDLE) && run && input_base_tvalid && input_modulus_tvalid;

   assign output_tvalid = (state == DONE);
   assign output_tdata  = dout;
   assign output_tuser  = derr;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         u     <= '0;
         v     <= '0;
         x1    <= '0;
         x2    <= '0;
         m_q   <= '0;
         iter  <= '0;
         dout  <= '0;
         derr  <= 1'b0;
      end else begin
         state <= state_nxt;
         u     <= u_nxt;
         v     <= v_nxt;
         x1    <= x1_nxt;
         x2    <= x2_nxt;
         m_q   <= m_nxt;
         iter  <= iter_nxt;
         dout  <= dout_nxt;
         derr  <= derr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      u_nxt     = u;
      v_nxt     = v;
      x1_nxt    = x1;
      x2_nxt    = x2;
      m_nxt     = m_q;
      iter_nxt  = iter;
      dout_nxt  = dout;
      derr_nxt  = derr;
      unique case (state)
         IDLE: begin
            if (accept) begin
               u_nxt     = input_base_tdata;
               v_nxt     = input_modulus_tdata;
               m_nxt     = input_modulus_tdata;
               x1_nxt    = SIZE'(1);
               x2_nxt    = '0;
               iter_nxt  = '0;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (!m_q[0] || (m_q < SIZE'(3)) || (u == '0) || (u >= m_q)) begin
               dout_nxt  = '0;
               derr_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = HALVE_U;
            end
         end
         HALVE_U: begin
            iter_nxt = iter + 1'b1;
            // u == 0 can only come from u == v in SUB, i.e. gcd > 1
            if ((iter == ITER_LAST) || (u == '0)) begin
               dout_nxt  = '0;
               derr_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (u == SIZE'(1)) begin
               dout_nxt  = x1;
               derr_nxt  = 1'b0;
               state_nxt = DONE;
            end else if (!u[0]) begin
               u_nxt  = u >> 1;
               x1_nxt = half_mod(x1, m_q);
            end else begin
               state_nxt = HALVE_V;
            end
         end
         HALVE_V: begin
            iter_nxt = iter + 1'b1;
            if ((iter == ITER_LAST) || (v == '0)) begin
               dout_nxt  = '0;
               derr_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (v == SIZE'(1)) begin
               dout_nxt  = x2;
               derr_nxt  = 1'b0;
               state_nxt = DONE;
            end else if (!v[0]) begin
               v_nxt  = v >> 1;
               x2_nxt = half_mod(x2, m_q);
            end else begin
               state_nxt = SUB;
            end
         end
         SUB: begin
            iter_nxt = iter + 1'b1;
            if (iter == ITER_LAST) begin
               dout_nxt  = '0;
               derr_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               if (u >= v) begin
                  u_nxt  = u - v;
                  x1_nxt = sub_mod(x1, x2, m_q);
               end else begin
                  v_nxt  = v - u;
                  x2_nxt = sub_mod(x2, x1, m_q);
               end
               state_nxt = HALVE_U;
            end
         end
         DONE: begin
            if (output_tready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mod_inverse_stream.sv
module tb_mod_inverse_stream;

   localparam int SIZE     = 64;
   localparam int MAX_ITER = 4*SIZE+4;
   localparam int LAT_MAX  = MAX_ITER+3;

   logic            clk;
   logic            rst;
   logic [SIZE-1:0] base_data;
   logic            base_valid;
   logic            input_base_tready;
   logic [SIZE-1:0] mod_data;
   logic            mod_valid;
   logic            input_modulus_tready;
   logic [SIZE-1:0] output_tdata;
   logic            output_tuser;
   logic            output_tvalid;
   logic            output_tready;
   logic            busy;

   int checks = 0;
   int errors = 0;

   mod_inverse_stream #(.SIZE(SIZE), .MAX_ITER(MAX_ITER)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .input_base_tdata     (base_data),
      .input_base_tvalid    (base_valid),
      .input_base_tready    (input_base_tready),
      .input_modulus_tdata  (mod_data),
      .input_modulus_tvalid (mod_valid),
      .input_modulus_tready (input_modulus_tready),
      .output_tdata         (output_tdata),
      .output_tuser         (output_tuser),
      .output_tvalid        (output_tvalid),
      .output_tready        (output_tready),
      .busy                 (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: classic extended Euclid on integers; ok=0 when gcd(a,m) > 1.
   function automatic longint ref_inv(input longint a, input longint m, output bit ok);
      longint t, nt, r, nr, q, tmp;
      t = 0; nt = 1; r = m; nr = a;
      while (nr != 0) begin
         q   = r / nr;
         tmp = t - q*nt; t = nt; nt = tmp;
         tmp = r - q*nr; r = nr; nr = tmp;
      end
      ok = (r == 1);
      if (t < 0) t = t + m;
      return ok ? t : 0;
   endfunction

   // Present both operands, wait for acceptance, then wait for output_tvalid.
   // lat counts rising edges from the accepting edge up to and including the
   // first edge at which output_tvalid is seen high.
   task automatic do_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] m,
                        output logic [SIZE-1:0] d, output logic e,
                        output int lat, output bit to);
      int n;
      to  = 1'b0;
      lat = 0;
      d   = '0;
      e   = 1'b0;
      @(negedge clk);
      base_data = a; mod_data = m; base_valid = 1'b1; mod_valid = 1'b1;
      n = 0;
      while (!(input_base_tready && input_modulus_tready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         base_valid = 1'b0; mod_valid = 1'b0; to = 1'b1;
         return;
      end
      @(posedge clk);
      #1 base_valid = 1'b0; mod_valid = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (output_tvalid) begin
            lat++;
            break;
         end
         if (lat > LAT_MAX + 20) begin
            to = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      d = output_tdata;
      e = output_tuser;
   endtask

   task automatic complete_out();
      @(negedge clk);
      output_tready = 1'b1;
      @(posedge clk);
      #1 output_tready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      base_valid = 1'b0; mod_valid = 1'b0; output_tready = 1'b0;
      base_data = '0; mod_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (output_tvalid !== 1'b0 || busy !== 1'b0 || output_tdata !== '0 || output_tuser !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: tvalid=%b busy=%b tdata=%0h tuser=%b, required 0 0 0 0",
                  output_tvalid, busy, output_tdata, output_tuser);
      end
      checks++;
      if (input_base_tready !== 1'b1 || input_modulus_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tready: base=%b mod=%b, required 1 1", input_base_tready, input_modulus_tready);
      end
      base_data = 64'd1; mod_data = 64'd3; base_valid = 1'b1; mod_valid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_edge_accept: busy=%b, required 0", busy);
      end
      base_valid = 1'b0; mod_valid = 1'b0;
   endtask

   task automatic test_unit_base();
      logic [SIZE-1:0] d; logic e; int lat; bit to;
      do_op(64'd1, 64'd3, d, e, lat, to);
      checks++;
      if (to || d !== 64'd1 || e !== 1'b0) begin
         errors++;
         $display("FAIL unit_base: timeout=%b tdata=%0d tuser=%b, required tdata=1 tuser=0", to, d, e);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL unit_base_latency: got %0d, required 4", lat);
      end
      complete_out();
   endtask

   task automatic test_basic();
      logic [SIZE-1:0] d; logic e; int lat; bit to; bit extra;
      do_op(64'd3, 64'd7, d, e, lat, to);
      checks++;
      if (to || d !== 64'd5 || e !== 1'b0) begin
         errors++;
         $display("FAIL basic_3_7: timeout=%b tdata=%0d tuser=%b, required 5 0", to, d, e);
      end
      checks++;
      if (lat > LAT_MAX) begin
         errors++;
         $display("FAIL basic_latency: got %0d, required <= %0d", lat, LAT_MAX);
      end
      complete_out();
      extra = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (output_tvalid) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL basic_single_transfer: tvalid seen again=%b, required 0", extra);
      end
   endtask

   task automatic test_size64();
      logic [SIZE-1:0] d; logic e; int lat; bit to;
      logic [SIZE-1:0] m;
      m = 64'h1FFF_FFFF_FFFF_FFFF;
      do_op(64'd2, m, d, e, lat, to);
      checks++;
      if (to || d !== 64'h1000_0000_0000_0000 || e !== 1'b0) begin
         errors++;
         $display("FAIL m61_a2: timeout=%b tdata=%0h tuser=%b, required 1000000000000000 0", to, d, e);
      end
      complete_out();
      do_op(m - 64'd1, m, d, e, lat, to);
      checks++;
      if (to || d !== m - 64'd1 || e !== 1'b0) begin
         errors++;
         $display("FAIL m61_am1: timeout=%b tdata=%0h tuser=%b, required %0h 0", to, d, e, m - 64'd1);
      end
      checks++;
      if (lat > LAT_MAX) begin
         errors++;
         $display("FAIL m61_latency: got %0d, required <= %0d", lat, LAT_MAX);
      end
      complete_out();
   endtask

   task automatic test_errors();
      logic [SIZE-1:0] ta [7];
      logic [SIZE-1:0] tm [7];
      logic [SIZE-1:0] d; logic e; int lat; bit to;
      ta = '{64'd6, 64'd3, 64'd7, 64'd0, 64'd2, 64'd1, 64'd9};
      tm = '{64'd9, 64'd8, 64'd7, 64'd7, 64'd1, 64'd2, 64'd7};
      for (int i = 0; i < 7; i++) begin
         do_op(ta[i], tm[i], d, e, lat, to);
         checks++;
         if (to || e !== 1'b1 || d !== '0) begin
            errors++;
            $display("FAIL error_case a=%0d m=%0d: timeout=%b tuser=%b tdata=%0d, required tuser=1 tdata=0",
                     ta[i], tm[i], to, e, d);
         end
         complete_out();
      end
   endtask

   task automatic test_backpressure();
      logic [SIZE-1:0] d; logic e; int lat; bit to; int n;
      bit held_ok; bit ready_low;
      do_op(64'd5, 64'd11, d, e, lat, to);
      checks++;
      if (to || d !== 64'd9 || e !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: timeout=%b tdata=%0d tuser=%b, required 9 0", to, d, e);
      end
      base_data = 64'd3; mod_data = 64'd7; base_valid = 1'b1; mod_valid = 1'b1;
      held_ok = 1'b1; ready_low = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (output_tvalid !== 1'b1 || output_tdata !== 64'd9 || output_tuser !== 1'b0) held_ok = 1'b0;
         if (input_base_tready !== 1'b0 || input_modulus_tready !== 1'b0) ready_low = 1'b0;
      end
      checks++;
      if (!held_ok) begin
         errors++;
         $display("FAIL bp_hold: tvalid/tdata/tuser not held, last tvalid=%b tdata=%0d, required 1 9", output_tvalid, output_tdata);
      end
      checks++;
      if (!ready_low) begin
         errors++;
         $display("FAIL bp_tready_low: tready rose during DONE, required 0");
      end
      // Handshake with new operands already waiting: no accept on that edge.
      @(negedge clk);
      output_tready = 1'b1;
      @(posedge clk);
      #1 output_tready = 1'b0;
      checks++;
      if (output_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_after_handshake: tvalid=%b busy=%b, required 0 0", output_tvalid, busy);
      end
      @(posedge clk);
      #1 base_valid = 1'b0; mod_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_next_accept: busy=%b, required 1", busy);
      end
      n = 0;
      while (!output_tvalid && n < LAT_MAX + 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (output_tvalid !== 1'b1 || output_tdata !== 64'd5 || output_tuser !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_result: tvalid=%b tdata=%0d tuser=%b, required 1 5 0",
                  output_tvalid, output_tdata, output_tuser);
      end
      complete_out();
   endtask

   task automatic test_reset_mid();
      logic [SIZE-1:0] d; logic e; int lat; bit to; int n; bit leak;
      @(negedge clk);
      base_data = 64'd3; mod_data = 64'd7; base_valid = 1'b1; mod_valid = 1'b1;
      n = 0;
      while (!input_base_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 base_valid = 1'b0; mod_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (output_tvalid !== 1'b0 || busy !== 1'b0 || output_tdata !== '0 || output_tuser !== 1'b0
          || input_base_tready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async: tvalid=%b busy=%b tdata=%0d tuser=%b tready=%b, required 0 0 0 0 1",
                  output_tvalid, busy, output_tdata, output_tuser, input_base_tready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      output_tready = 1'b1;
      leak = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (output_tvalid) leak = 1'b1;
      end
      output_tready = 1'b0;
      checks++;
      if (leak) begin
         errors++;
         $display("FAIL midreset_no_output: tvalid seen=%b, required 0", leak);
      end
      do_op(64'd4, 64'd7, d, e, lat, to);
      checks++;
      if (to || d !== 64'd2 || e !== 1'b0) begin
         errors++;
         $display("FAIL midreset_next: timeout=%b tdata=%0d tuser=%b, required 2 0", to, d, e);
      end
      complete_out();
   endtask

   task automatic test_random();
      logic [SIZE-1:0] d; logic e; int lat; bit to;
      longint a, m, exp_r; bit ok;
      for (int i = 0; i < 40; i++) begin
         m = (longint'($urandom_range(1, (1 << 23) - 1)) << 1) | 1;
         a = longint'($urandom_range(1, 32'(m - 1)));
         exp_r = ref_inv(a, m, ok);
         do_op(64'(a), 64'(m), d, e, lat, to);
         checks++;
         if (to || e !== !ok || d !== 64'(exp_r)) begin
            errors++;
            $display("FAIL random a=%0d m=%0d: timeout=%b tdata=%0d tuser=%b, required tdata=%0d tuser=%b",
                     a, m, to, d, e, exp_r, !ok);
         end
         checks++;
         if (ok && ((a * longint'(d)) % m) != 1) begin
            errors++;
            $display("FAIL random_product a=%0d m=%0d: a*r mod m=%0d, required 1", a, m, (a * longint'(d)) % m);
         end
         checks++;
         if (lat > LAT_MAX) begin
            errors++;
            $display("FAIL random_latency a=%0d m=%0d: got %0d, required <= %0d", a, m, lat, LAT_MAX);
         end
         complete_out();
      end
   endtask

   initial begin
      test_reset();
      test_unit_base();
      test_basic();
      test_size64();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mod_inverse_stream.md
MOD_INVERSE_STREAM -- requirements
Module: mod_inverse_stream

Interface
REQ-001 SHALL have parameter SIZE, default 64, giving the operand/result width in bits (min 4).
REQ-002 SHALL have parameter MAX_ITER, default 4*SIZE+4, giving the iteration bound before a forced error result.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port input_base_tdata  input  SIZE  unsigned base a.
REQ-006 Port input_base_tvalid  input  1  base valid.
REQ-007 Port input_base_tready  output  1  base ready.
REQ-008 Port input_modulus_tdata  input  SIZE  unsigned modulus m.
REQ-009 Port input_modulus_tvalid  input  1  modulus valid.
REQ-010 Port input_modulus_tready  output  1  modulus ready.
REQ-011 Port output_tdata  output  SIZE  inverse a^-1 mod m, in [0, m).
REQ-012 Port output_tuser  output  1  error: no inverse or illegal operands.
REQ-013 Port output_tvalid  output  1  result valid.
REQ-014 Port output_tready  input  1  downstream ready.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, CHECK, HALVE_U, HALVE_V, SUB, DONE.
REQ-017 Both input tready SHALL be high only in IDLE; a transfer occurs in the cycle where state is IDLE and both tvalids are high, and both operands are captured together in that cycle.
REQ-018 On acceptance: u<=a, v<=m, x1<=1, x2<=0, iteration counter<=0, next state CHECK.
REQ-019 CHECK: if m even, m<3, a==0 or a>=m -> DONE with error=1, data=0; else -> HALVE_U.
REQ-020 HALVE_U: u==1 -> DONE, result x1; u even -> u<=u>>1, x1<=x1 even ? x1/2 : (x1+m)/2, stay; u odd -> HALVE_V.
REQ-021 HALVE_V: v==1 -> DONE, result x2; v even -> same halving applied to v/x2, stay; v odd -> SUB.
REQ-022 SUB: u>=v -> u<=u-v, x1<=x1-x2 (plus m if negative); else v<=v-u, x2<=x2-x1 (plus m if negative); -> HALVE_U.
REQ-023 A subtraction result of u==0 or v==0 SHALL be detected in the following HALVE state -> DONE with error=1, data=0 (gcd>1).
REQ-024 x1, x2 SHALL stay in [0, m) at all times; intermediates x+m computed in SIZE+1 bits, no overflow for any SIZE-bit m.
REQ-025 Iteration counter SHALL increment on every HALVE/SUB cycle; reaching MAX_ITER -> DONE with error=1 (must never fire for legal operands).
REQ-026 Exactly one state action per cycle; latency accept-to-tvalid ≤ MAX_ITER+3 cycles; a=1 yields tvalid 4 cycles after acceptance.
REQ-027 DONE: output_tvalid=1, tdata/tuser stable until output_tready sampled high; then -> IDLE, tvalid low the next cycle.
REQ-028 output_tdata/output_tuser SHALL change only on entry to DONE.
REQ-029 Inputs are not re-accepted in DONE, even with output_tready high; next acceptance no earlier than the cycle after the output handshake.

Reset
REQ-030 rst low SHALL immediately force state IDLE, output_tvalid=0, output_tdata=0, output_tuser=0, busy=0, input treadys as per IDLE (1).
REQ-031 Reset mid-computation or during DONE SHALL discard the operation; no output transfer follows.
REQ-032 Reset deassertion SHALL be synchronised internally so the first acceptance is no earlier than the second rising edge after rst rises.

Verification
REQ-033 a=3, m=7, output_tready=1 -> one transfer tdata=5, tuser=0.
REQ-034 SIZE=64: a=2, m=2^61-1 -> tdata=2^60, tuser=0; a=m-1 -> tdata=m-1.
REQ-035 a=6, m=9 -> tuser=1, tdata=0; m=8 -> tuser=1; a=7, m=7 -> tuser=1.
REQ-036 a=5, m=11, output_tready low 20 cycles -> tvalid held, tdata=9 stable, input treadys low until transfer.
REQ-037 rst pulsed low 10 cycles after acceptance of a=3, m=7 -> tvalid stays 0; next operands a=4, m=7 accepted -> tdata=2.
REQ-038 Random odd m, random a in [1, m): result checked against reference a*r mod m==1 or gcd>1 with tuser=1; latency ≤ MAX_ITER+3.
